mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
- Memory-side responder for the cache line interface: answers `mem_read`/`mem_write` from a cache with 128-bit lines after a programmable latency.
- Sits below `cache`/`icache_wrapper` in simulation and FPGA builds, standing in for slow main memory.
- Holds a small line-addressed backing store and drives `mem_ready`/`mem_rdata` per the cache handshake.

Parameters:
- LATENCY, 4, cycles from request acceptance to `mem_ready` pulse; legal 1..255.
- ADDR_BITS, 8, number of low `mem_addr` bits used as line index; store depth = 2**ADDR_BITS lines.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read  in  1  line read request; held by cache until `mem_ready`.
- mem_write  in  1  line write request; held by cache until `mem_ready`.
- mem_addr  in  28  line address (byte address [31:4]).
- mem_wdata  in  128  write line data.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  128  read line data, valid in the `mem_ready` cycle.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, counter=0, `mem_ready`=0, `mem_rdata`=0, `proto_err`=0. Backing store is NOT cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `mem_write`=1 or `mem_read`=1 at edge t: latch op, `mem_addr[ADDR_BITS-1:0]` and `mem_wdata`, load counter=LATENCY-1.
  - Go to RESP if LATENCY=1, else BUSY.
- BUSY:
  - Decrement counter each cycle; at counter reaching 0 go to RESP.
  - Net effect: `mem_ready` is high exactly in cycle t+LATENCY.
- RESP (one cycle):
  - `mem_ready`=1.
  - Read: `mem_rdata` = store[latched index].
  - Write: store[latched index] <= latched wdata at this edge.
  - Next state is IDLE.
- `mem_ready` is registered and never high for two consecutive cycles.
- Between requests, IDLE lasts at least one cycle; back-to-back requests see turnaround of LATENCY+1 cycles.
- `mem_rdata` holds its last value outside RESP; for writes it is unchanged.
- Both `mem_read` and `mem_write` high in IDLE:
  - Write wins; read is ignored.
  - `proto_err` sets at that edge and stays high until reset.
- Request dropped in BUSY (both inputs low):
  - Abort: return to IDLE next cycle, no `mem_ready`, no store update, `proto_err` set.
- Address/data changed while BUSY: ignored; the latched values are used.
- Index wrap: addresses differing only above ADDR_BITS alias to the same line.
- Reset mid-operation: returns to IDLE immediately and outputs clear. A pending write is discarded; store contents persist.

Optional Feature:
- MEM_RANDOM_LATENCY_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - At acceptance, the counter loads LATENCY-1 + lfsr[2:0], so latency varies from LATENCY to LATENCY+7.
  - All handshake rules are unchanged.
- Not defined: fixed latency, no LFSR logic.

Test Plan:
- Reset then read addr 28'h0000005 (LATENCY=4), request at t -> `mem_ready`=1 only at t+4; `mem_rdata` = prior store content; `proto_err`=0.
- Write 28'h0000010 with wdata 128'hDEADBEEF_0123_4567_89AB_CDEF_CAFEF00D, then read same addr -> second `mem_ready` returns identical 128-bit value.
- Write 28'h0000103 data A, then read 28'h0000003 (ADDR_BITS=8) -> returns A (alias).
- `mem_read`=`mem_write`=1 in IDLE with addr 28'h20, wdata B -> write performed (later read of 28'h20 returns B); `proto_err`=1 sticky.
- Read issued, `mem_read` dropped after 2 cycles -> no `mem_ready` pulse; FSM back in IDLE; `proto_err`=1; next valid read completes in LATENCY cycles.
- rst_n=0 during BUSY of a write to 28'h30 -> `mem_ready` never pulses; after reset, read 28'h30 returns the pre-write value.

Source files
------------

// File: rtl/mem_line_responder_if.sv
// Cache-to-memory line bus: one request per transaction, completed by a single mem_ready pulse.
// Handshake: the cache raises mem_read or mem_write with mem_addr/mem_wdata and holds them until it
// samples mem_ready=1. mem_rdata is valid only in that cycle. Dropping the request early is a protocol error.
interface mem_line_responder_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic         proto_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_ready, mem_rdata, proto_err
  );
endinterface

// File: rtl/mem_line_responder.sv
// Slow-memory stand-in: answers 128-bit line reads/writes after LATENCY cycles from a line-indexed store.
// Optional MEM_RANDOM_LATENCY_EN adds 0..7 cycles of LFSR-driven jitter per request.
module mem_line_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_line_responder_if.slave bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [8:0]             cnt, cnt_nx;
  logic [8:0]             load_val;
  logic                   op_wr, op_wr_nx;
  logic [ADDR_BITS-1:0]   idx, idx_nx;
  logic [127:0]           wdata_q, wdata_nx;
  logic                   err_q, err_nx;
  logic                   ready_q;
  logic [127:0]           rdata_q;
  logic [127:0]           store [2**ADDR_BITS];

  // Address bits above the line index alias onto the same line.
  logic unused_addr;
  assign unused_addr = ^bus.mem_addr[27:ADDR_BITS];

`ifdef MEM_RANDOM_LATENCY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign load_val = 9'(LATENCY - 1) + {6'd0, lfsr[2:0]};
`else
  assign load_val = 9'(LATENCY - 1);
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_wr_nx = op_wr;
    idx_nx   = idx;
    wdata_nx = wdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (bus.mem_write || bus.mem_read) begin
          // Write wins when both are raised; the collision is still flagged.
          op_wr_nx = bus.mem_write;
          idx_nx   = bus.mem_addr[ADDR_BITS-1:0];
          wdata_nx = bus.mem_wdata;
          cnt_nx   = load_val;
          if (bus.mem_write && bus.mem_read) begin
            err_nx = 1'b1;
          end
          state_nx = (load_val == 9'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!bus.mem_read && !bus.mem_write) begin
          state_nx = IDLE;
          cnt_nx   = 9'd0;
          err_nx   = 1'b1;
        end else if (cnt <= 9'd1) begin
          state_nx = RESP;
          cnt_nx   = 9'd0;
        end else begin
          cnt_nx = cnt - 9'd1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // mem_ready and read data are registered on entry to RESP so they are visible for exactly that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 9'd0;
      op_wr   <= 1'b0;
      idx     <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      op_wr   <= op_wr_nx;
      idx     <= idx_nx;
      wdata_q <= wdata_nx;
      err_q   <= err_nx;
      ready_q <= (state_nx == RESP);
      if (state_nx == RESP && !op_wr_nx) begin
        rdata_q <= store[idx_nx];
      end
    end
  end

  // Backing store survives reset; a write still in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && state == RESP && op_wr) begin
      store[idx] <= wdata_q;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.proto_err = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: vector table, directed corner sequences and
// randomized traffic checked against a line-array memory model.
module tb_mem_line_responder;

  localparam int L     = 4;
  localparam int DEPTH = 256;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mem_line_responder_if bus ();

  mem_line_responder #(.LATENCY(L), .ADDR_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [127:0]  exp_q[$];
  logic [127:0]  model_mem [int];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    rst_n         = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives a request now (caller sits at a negedge) and waits for mem_ready; leaves the request driven.
  task automatic req(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                     output int lat, output logic [127:0] rdata);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    lat   = -1;
    rdata = '0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) begin
        lat   = i;
        rdata = bus.mem_rdata;
        break;
      end
    end
  endtask

  // Releases the request and confirms the completion pulse lasted a single cycle.
  task automatic drop();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("ready_single_cycle", {127'd0, bus.mem_ready}, 128'd0);
  endtask

  // Watches mem_ready for a number of cycles and reports whether it ever rose.
  task automatic watch_ready(input int cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.mem_ready !== 1'b0) seen = 1'b1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  localparam logic [127:0] DA = 128'hDEADBEEF_0123_4567_89AB_CDEF_CAFEF00D;
  localparam logic [127:0] VA = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] VC = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] VD = 128'hFFFFFFFF_00000000_FFFFFFFF_00000001;
  localparam logic [127:0] VB = 128'hBBBB0000_CCCC1111_DDDD2222_EEEE3333;
  localparam logic [127:0] VP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] VQ = 128'h99999999_88888888_77777777_66666666;

  initial begin
    int           lat;
    int           gap;
    logic [127:0] rd;
    logic [127:0] exp;
    bit           seen;
    bit           b2b;
    bit           wr;
    int           idx;
    logic [27:0]  a;
    logic [127:0] d;

    vecs[0] = '{1'b1, 28'h0000010, DA, 128'd0};
    vecs[1] = '{1'b0, 28'h0000010, 128'd0, DA};
    vecs[2] = '{1'b1, 28'h0000103, VA, 128'd0};
    vecs[3] = '{1'b0, 28'h0000003, 128'd0, VA};
    vecs[4] = '{1'b1, 28'h7FFFF10, VC, 128'd0};
    vecs[5] = '{1'b0, 28'h0000010, 128'd0, VC};
    vecs[6] = '{1'b1, 28'h00000FF, VD, 128'd0};
    vecs[7] = '{1'b0, 28'hABCDEFF, 128'd0, VD};
    vecs[8] = '{1'b0, 28'h0000103, 128'd0, VA};
    vecs[9] = '{1'b0, 28'h0000203, 128'd0, VA};

    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    do_reset(3);

    // Reset state
    check("reset_ready", {127'd0, bus.mem_ready}, 128'd0);
    check("reset_rdata", bus.mem_rdata, 128'd0);
    check("reset_proto_err", {127'd0, bus.proto_err}, 128'd0);

    // Read of an untouched line: timing and error flag only, contents are whatever was there
    req(1'b1, 1'b0, 28'h0000005, 128'd0, lat, rd);
    check("first_read_latency", 128'(lat), 128'(L));
    check("first_read_proto_err", {127'd0, bus.proto_err}, 128'd0);
    drop();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      req(!vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(L));
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      else model_mem[int'(vecs[i].addr) % DEPTH] = vecs[i].wdata;
      drop();
    end
    check("table_proto_err", {127'd0, bus.proto_err}, 128'd0);

    // Back-to-back: write then read with no idle gap sees LATENCY+1 turnaround and the new data
    req(1'b0, 1'b1, 28'h0000044, VQ, lat, rd);
    check("b2b_write_latency", 128'(lat), 128'(L));
    model_mem[16'h44] = VQ;
    req(1'b1, 1'b0, 28'h0000044, 128'd0, lat, rd);
    check("b2b_read_latency", 128'(lat), 128'(L + 1));
    check("b2b_read_rdata", rd, VQ);
    drop();

    // Write-data hold: rdata keeps the last read value across a write
    req(1'b0, 1'b1, 28'h0000045, VP, lat, rd);
    check("write_keeps_rdata", rd, VQ);
    model_mem[16'h45] = VP;
    drop();

    // Read and write together: write wins, error is sticky
    req(1'b1, 1'b1, 28'h0000020, VB, lat, rd);
    check("collide_latency", 128'(lat), 128'(L));
    check("collide_proto_err", {127'd0, bus.proto_err}, 128'd1);
    model_mem[32] = VB;
    drop();
    req(1'b1, 1'b0, 28'h0000020, 128'd0, lat, rd);
    check("collide_readback", rd, VB);
    check("collide_err_sticky", {127'd0, bus.proto_err}, 128'd1);
    drop();

    // Early drop of a read: aborted with no pulse, error set, next read is normal
    do_reset(2);
    check("err_cleared_by_reset", {127'd0, bus.proto_err}, 128'd0);
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.mem_addr  = 28'h0000040;
    repeat (2) @(negedge clk);
    bus.mem_read = 1'b0;
    watch_ready(8, seen);
    check("abort_no_ready", {127'd0, seen}, 128'd0);
    check("abort_proto_err", {127'd0, bus.proto_err}, 128'd1);
    req(1'b1, 1'b0, 28'h0000010, 128'd0, lat, rd);
    check("after_abort_latency", 128'(lat), 128'(L));
    check("after_abort_rdata", rd, model_mem[16]);
    drop();

    // Reset in the middle of a write: no pulse, write discarded, store kept
    req(1'b0, 1'b1, 28'h0000030, VP, lat, rd);
    model_mem[48] = VP;
    drop();
    req(1'b1, 1'b0, 28'h0000030, 128'd0, lat, rd);
    check("prewrite_readback", rd, VP);
    drop();
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h0000030;
    bus.mem_wdata = VQ;
    repeat (2) @(negedge clk);
    rst_n         = 1'b0;
    bus.mem_write = 1'b0;
    watch_ready(2, seen);
    rst_n = 1'b1;
    begin
      bit seen2;
      watch_ready(6, seen2);
      seen = seen | seen2;
    end
    check("reset_busy_no_ready", {127'd0, seen}, 128'd0);
    check("reset_busy_rdata_clear", bus.mem_rdata, 128'd0);
    check("reset_busy_proto_err", {127'd0, bus.proto_err}, 128'd0);
    req(1'b1, 1'b0, 28'h0000030, 128'd0, lat, rd);
    check("reset_busy_latency", 128'(lat), 128'(L));
    check("reset_busy_store_kept", rd, VP);
    drop();

    // Randomized traffic against the line-array model
    for (int n = 0; n < 60; n++) begin
      b2b = (n > 0) && ($urandom_range(0, 4) == 0);
      if (!b2b && n > 0) begin
        drop();
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
      end
      idx = $urandom_range(0, 15);
      a   = 28'($urandom_range(0, 3) * DEPTH + idx);
      d   = {$urandom(), $urandom(), $urandom(), $urandom()};
      wr  = ($urandom_range(0, 1) == 1) || !model_mem.exists(idx);
      if (wr) model_mem[idx] = d;
      else exp_q.push_back(model_mem[idx]);
      req(!wr, wr, a, d, lat, rd);
      check($sformatf("rand%0d_latency", n), 128'(lat), b2b ? 128'(L + 1) : 128'(L));
      if (!wr) begin
        exp = exp_q.pop_front();
        check($sformatf("rand%0d_rdata", n), rd, exp);
      end
    end
    drop();
    check("rand_proto_err", {127'd0, bus.proto_err}, 128'd0);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
